// File: rtl/mousetrap_sync_pipe.sv
`timescale 1ns/1ps
// Purpose: clocked MouseTrap-style two-phase bundled-data pipeline of DEPTH stages.
// Latency: DEPTH edges from a sampled in_req toggle to out_req into an empty pipe (+2 with SYNC=1).
// Backpressure: a stage captures only when empty; a stalled out_ack freezes the pipe and stops in_ack.
module mousetrap_sync_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter bit SYNC  = 1'b0
) (
  input  logic                         Clk,
  input  logic                         extReset,
  input  logic                         in_req,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ack,
  output logic                         out_req,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ack,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Empty,
  output logic                         Full,
  output logic                         Overrun
);

  localparam int CW = $clog2(DEPTH+1);

  // r / a are the request and acknowledge phases as seen by the pipe
  logic r;
  logic a;

  generate
    if (SYNC) begin : g_sync
      logic [1:0] req_sync;
      logic [1:0] ack_sync;

      // two-flop synchronisers for the asynchronous handshake inputs
      always_ff @(posedge Clk or negedge extReset) begin
        if (!extReset) begin
          req_sync <= '0;
          ack_sync <= '0;
        end else begin
          req_sync <= {req_sync[0], in_req};
          ack_sync <= {ack_sync[0], out_ack};
        end
      end

      assign r = req_sync[1];
      assign a = ack_sync[1];
    end else begin : g_direct
      assign r = in_req;
      assign a = out_ack;
    end
  endgenerate

  // Stage state: one phase bit and one data word per stage
  logic [DEPTH-1:0] p;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] dprev [DEPTH];

  // Extended phase chain: pe[0] = r, pe[i+1] = p[i], pe[DEPTH+1] = a
  logic [DEPTH+1:0] pe;
  logic [DEPTH-1:0] full;
  logic [DEPTH-1:0] cap;
  logic             rl;

  assign pe = {a, p, r};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // full: this stage holds a token its successor has not yet taken
      assign full[gi] = pe[gi+1] ^ pe[gi+2];
      // capture when the predecessor offers a token and this stage is empty
      assign cap[gi]  = (pe[gi] ^ pe[gi+1]) & ~full[gi];
      if (gi == 0) begin : g_head
        assign dprev[gi] = in_data;
      end else begin : g_link
        assign dprev[gi] = d[gi-1];
      end
    end
  endgenerate

  // All stages update together from pre-edge phases; non-capturing stages hold
  always_ff @(posedge Clk or negedge extReset) begin
    if (!extReset) begin
      p <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cap[i]) begin
          p[i] <= pe[i];
          d[i] <= dprev[i];
        end
      end
    end
  end

  // Sticky protocol-violation detector: a new toggle while the previous one is unacknowledged.
  // The offending second toggle returns r to p[0], so no stage ever re-captures that token.
  always_ff @(posedge Clk or negedge extReset) begin
    if (!extReset) begin
      rl      <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      rl <= r;
      if ((r != rl) && (rl != p[0])) begin
        Overrun <= 1'b1;
      end
    end
  end

  assign in_ack   = p[0];
  assign out_req  = p[DEPTH-1];
  assign out_data = d[DEPTH-1];

  // Occupancy: popcount of full stages along the phase chain
  always_comb begin
    Count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      Count = Count + CW'(full[i]);
    end
  end

  assign Empty = (Count == '0);
  assign Full  = (Count == CW'(DEPTH));

endmodule

// File: tb/tb_mousetrap_sync_pipe.sv
`timescale 1ns/1ps
module tb_mousetrap_sync_pipe;

  logic       Clk = 1'b0;
  logic       extReset = 1'b1;
  logic       in_req = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ack = 1'b0;

  // DUT A: WIDTH=8, DEPTH=4, SYNC=0
  logic       in_ack, out_req, Empty, Full, Overrun;
  logic [7:0] out_data;
  logic [2:0] Count;
  // DUT B: SYNC=1
  logic       s_in_ack, s_out_req, s_empty, s_full, s_overrun;
  logic [7:0] s_out_data;
  logic [2:0] s_count;
  // DUT C: DEPTH=1
  logic       c_in_ack, c_out_req, c_empty, c_full, c_overrun;
  logic [7:0] c_out_data;
  logic [0:0] c_count;

  mousetrap_sync_pipe #(.WIDTH(8), .DEPTH(4), .SYNC(1'b0)) dut (
    .Clk(Clk), .extReset(extReset), .in_req(in_req), .in_data(in_data),
    .in_ack(in_ack), .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .Count(Count), .Empty(Empty), .Full(Full), .Overrun(Overrun));

  mousetrap_sync_pipe #(.WIDTH(8), .DEPTH(4), .SYNC(1'b1)) dut_sync (
    .Clk(Clk), .extReset(extReset), .in_req(in_req), .in_data(in_data),
    .in_ack(s_in_ack), .out_req(s_out_req), .out_data(s_out_data), .out_ack(out_ack),
    .Count(s_count), .Empty(s_empty), .Full(s_full), .Overrun(s_overrun));

  mousetrap_sync_pipe #(.WIDTH(8), .DEPTH(1), .SYNC(1'b0)) dut_one (
    .Clk(Clk), .extReset(extReset), .in_req(in_req), .in_data(in_data),
    .in_ack(c_in_ack), .out_req(c_out_req), .out_data(c_out_data), .out_ack(out_ack),
    .Count(c_count), .Empty(c_empty), .Full(c_full), .Overrun(c_overrun));

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: tokens in acceptance order, tokens seen at the output,
  // and occupancy as accepted-minus-acknowledged.
  logic [7:0] sent_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         n_acc, n_del;
  logic       last_ack, last_oreq;
  bit         src_en, snk_en;
  int         src_pct, snk_pct, src_left;

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    if (in_ack !== last_ack) begin
      last_ack = in_ack;
      sent_q.push_back(in_data);
      n_acc++;
    end
    if (out_req !== last_oreq) begin
      last_oreq = out_req;
      got_q.push_back(out_data);
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic drive();
    if (src_en && src_left > 0 && in_ack == in_req && int'($urandom_range(99)) < src_pct) begin
      in_data = 8'($urandom);
      in_req  = ~in_req;
      src_left--;
    end
    if (snk_en && out_req != out_ack && int'($urandom_range(99)) < snk_pct) begin
      out_ack = ~out_ack;
      n_del++;
    end
  endtask

  task automatic clear_model();
    sent_q.delete(); got_q.delete(); got_cyc.delete();
    n_acc = 0; n_del = 0; last_ack = 1'b0; last_oreq = 1'b0;
    src_en = 1'b0; snk_en = 1'b0; src_left = 0; src_pct = 0; snk_pct = 0;
  endtask

  task automatic apply_reset();
    extReset = 1'b0;
    in_req = 1'b0; out_ack = 1'b0; in_data = 8'h00;
    clear_model();
    repeat (2) @(posedge Clk);
    #1;
    extReset = 1'b1;
  endtask

  task automatic send_token(input logic [7:0] v, output bit ok);
    in_data = v;
    in_req  = ~in_req;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (in_ack === in_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] want16;
    logic [13:0] want14;
    want16 = {1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0};
    want14 = {1'b0, 1'b0, 8'h00, 1'd0, 1'b1, 1'b0, 1'b0};
    #2;
    extReset = 1'b0;
    #1;
    checks++;
    if ({in_ack, out_req, out_data, Count, Empty, Full, Overrun} !== want16) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h",
               {in_ack, out_req, out_data, Count, Empty, Full, Overrun}, want16);
    end
    checks++;
    if ({s_in_ack, s_out_req, s_out_data, s_count, s_empty, s_full, s_overrun} !== want16) begin
      errors++;
      $display("FAIL reset_outputs_sync: got %h want %h",
               {s_in_ack, s_out_req, s_out_data, s_count, s_empty, s_full, s_overrun}, want16);
    end
    checks++;
    if ({c_in_ack, c_out_req, c_out_data, c_count, c_empty, c_full, c_overrun} !== want14) begin
      errors++;
      $display("FAIL reset_outputs_depth1: got %h want %h",
               {c_in_ack, c_out_req, c_out_data, c_count, c_empty, c_full, c_overrun}, want14);
    end
    apply_reset();
  endtask

  task automatic test_first_token();
    apply_reset();
    in_data = 8'hA5;
    in_req  = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (in_ack !== 1'b1) begin
        errors++; $display("FAIL first_in_ack edge %0d: got %b want 1", e, in_ack);
      end
      checks++;
      if (out_req !== ((e == 4) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL first_out_req edge %0d: got %b want %b", e, out_req, e == 4);
      end
      if (e == 1) begin
        checks++;
        if ({c_out_req, c_out_data, c_full} !== {1'b1, 8'hA5, 1'b1}) begin
          errors++; $display("FAIL depth1_pass: got req=%b data=%h full=%b want 1 a5 1",
                             c_out_req, c_out_data, c_full);
        end
      end
    end
    checks++;
    if (out_data !== 8'hA5) begin
      errors++; $display("FAIL first_out_data: got %h want a5", out_data);
    end
    checks++;
    if (Count !== 3'd1 || Empty !== 1'b0 || Full !== 1'b0) begin
      errors++; $display("FAIL first_count: got count=%0d empty=%b full=%b want 1 0 0", Count, Empty, Full);
    end
  endtask

  task automatic test_sync();
    apply_reset();
    in_data = 8'hA5;
    in_req  = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (s_in_ack !== ((e >= 3) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL sync_in_ack edge %0d: got %b want %b", e, s_in_ack, e >= 3);
      end
      checks++;
      if (s_out_req !== ((e >= 6) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL sync_out_req edge %0d: got %b want %b", e, s_out_req, e >= 6);
      end
    end
    checks++;
    if (s_out_data !== 8'hA5) begin
      errors++; $display("FAIL sync_out_data: got %h want a5", s_out_data);
    end
  endtask

  task automatic test_fill();
    bit ok;
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      send_token(8'(k), ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL fill_accept token %0d: got no in_ack want in_ack", k);
      end
    end
    checks++;
    if (Full !== 1'b1 || Count !== 3'd4) begin
      errors++; $display("FAIL fill_full: got full=%b count=%0d want 1 4", Full, Count);
    end
    in_data = 8'h05;
    in_req  = ~in_req;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if ({in_ack, out_req, out_data, Count} !== {1'b0, 1'b1, 8'h01, 3'd4}) begin
        errors++; $display("FAIL fill_stall cycle %0d: got ack=%b req=%b data=%h count=%0d want 0 1 01 4",
                           e, in_ack, out_req, out_data, Count);
      end
    end
    snk_en = 1'b1; snk_pct = 100;
    for (int e = 0; e < 60 && got_q.size() < 5; e++) begin
      drive();
      tick();
    end
    checks++;
    if (got_q.size() !== 5) begin
      errors++; $display("FAIL fill_drain_count: got %0d want 5", got_q.size());
    end
    for (int k = 0; k < got_q.size() && k < 5; k++) begin
      checks++;
      if (got_q[k] !== 8'(k + 1)) begin
        errors++; $display("FAIL fill_order idx %0d: got %h want %h", k, got_q[k], 8'(k + 1));
      end
    end
    drive();
    tick();
    checks++;
    if (Empty !== 1'b1 || Count !== 3'd0) begin
      errors++; $display("FAIL fill_empty: got empty=%b count=%0d want 1 0", Empty, Count);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      send_token(8'(8'h10 + k), ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL ovr_fill token %0d: got no in_ack want in_ack", k);
      end
    end
    in_data = 8'h55;
    in_req  = ~in_req;
    tick(); tick();
    checks++;
    if (Overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_single_toggle: got %b want 0", Overrun);
    end
    in_req = ~in_req;
    tick();
    checks++;
    if (Overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_double_toggle: got %b want 1", Overrun);
    end
    snk_en = 1'b1; snk_pct = 100;
    for (int e = 0; e < 40; e++) begin
      drive();
      tick();
    end
    checks++;
    if (Overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_sticky: got %b want 1", Overrun);
    end
    checks++;
    if (got_q.size() !== 4 || Count !== 3'd0) begin
      errors++; $display("FAIL ovr_no_dup: got delivered=%0d count=%0d want 4 0", got_q.size(), Count);
    end
    #2;
    extReset = 1'b0;
    #1;
    checks++;
    if (Overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_reset_clear: got %b want 0", Overrun);
    end
    apply_reset();
  endtask

  task automatic test_throughput();
    int t0;
    apply_reset();
    src_en = 1'b1; src_pct = 100; src_left = 24;
    snk_en = 1'b1; snk_pct = 100;
    drive();
    t0 = cyc;
    for (int e = 0; e < 200 && got_q.size() < 24; e++) begin
      tick();
      drive();
    end
    checks++;
    if (got_q.size() !== 24 || sent_q.size() !== 24) begin
      errors++; $display("FAIL tput_count: got out=%0d in=%0d want 24 24", got_q.size(), sent_q.size());
    end
    checks++;
    if (got_cyc.size() > 0 && got_cyc[0] - t0 !== 4) begin
      errors++; $display("FAIL tput_latency: got %0d want 4", got_cyc[0] - t0);
    end
    for (int k = 1; k < got_cyc.size(); k++) begin
      checks++;
      if (got_cyc[k] - got_cyc[k-1] !== 2) begin
        errors++; $display("FAIL tput_interval idx %0d: got %0d want 2", k, got_cyc[k] - got_cyc[k-1]);
      end
    end
    for (int k = 0; k < got_q.size() && k < sent_q.size(); k++) begin
      checks++;
      if (got_q[k] !== sent_q[k]) begin
        errors++; $display("FAIL tput_data idx %0d: got %h want %h", k, got_q[k], sent_q[k]);
      end
    end
    checks++;
    if (Overrun !== 1'b0) begin
      errors++; $display("FAIL tput_overrun: got %b want 0", Overrun);
    end
  endtask

  task automatic test_random();
    int want_cnt;
    bit done;
    apply_reset();
    src_en = 1'b1; src_pct = 40; src_left = 60;
    snk_en = 1'b1; snk_pct = 35;
    done = 1'b0;
    for (int e = 0; e < 2000 && !done; e++) begin
      tick();
      want_cnt = n_acc - n_del;
      checks++;
      if (Count !== 3'(want_cnt) || Empty !== (want_cnt == 0) || Full !== (want_cnt == 4)) begin
        errors++; $display("FAIL rand_count cycle %0d: got count=%0d empty=%b full=%b want %0d",
                           e, Count, Empty, Full, want_cnt);
      end
      checks++;
      if (Overrun !== 1'b0) begin
        errors++; $display("FAIL rand_overrun cycle %0d: got %b want 0", e, Overrun);
      end
      done = (src_left == 0) && (n_acc == 60) && (got_q.size() == 60);
      drive();
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL rand_timeout: got in=%0d out=%0d want 60 60", n_acc, got_q.size());
    end
    for (int k = 0; k < got_q.size() && k < sent_q.size(); k++) begin
      checks++;
      if (got_q[k] !== sent_q[k]) begin
        errors++; $display("FAIL rand_order idx %0d: got %h want %h", k, got_q[k], sent_q[k]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    logic [15:0] want16;
    want16 = {1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    send_token(8'h11, ok);
    send_token(8'h22, ok);
    send_token(8'h33, ok);
    tick(); tick();
    checks++;
    if (Count !== 3'd3) begin
      errors++; $display("FAIL mid_count_before: got %0d want 3", Count);
    end
    #2;
    extReset = 1'b0;
    #1;
    checks++;
    if ({in_ack, out_req, out_data, Count, Empty, Full, Overrun} !== want16) begin
      errors++; $display("FAIL mid_reset_immediate: got %h want %h",
                         {in_ack, out_req, out_data, Count, Empty, Full, Overrun}, want16);
    end
    @(posedge Clk);
    #1;
    checks++;
    if ({in_ack, out_req, out_data, Count, Empty, Full, Overrun} !== want16) begin
      errors++; $display("FAIL mid_reset_held: got %h want %h",
                         {in_ack, out_req, out_data, Count, Empty, Full, Overrun}, want16);
    end
    clear_model();
    in_data  = 8'h77;
    extReset = 1'b1;
    tick();
    checks++;
    if (in_ack !== 1'b1) begin
      errors++; $display("FAIL mid_pending_ack: got %b want 1", in_ack);
    end
    tick(); tick(); tick();
    checks++;
    if ({out_req, out_data, Count} !== {1'b1, 8'h77, 3'd1}) begin
      errors++; $display("FAIL mid_pending_out: got req=%b data=%h count=%0d want 1 77 1",
                         out_req, out_data, Count);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_first_token();
    test_sync();
    test_fill();
    test_overrun();
    test_throughput();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mousetrap_sync_pipe.md
MOUSETRAP_SYNC_PIPE -- requirements
Module: mousetrap_sync_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data bits per token.
REQ-002 Parameter DEPTH, default 4: number of pipeline stages, legal range 1..16.
REQ-003 Parameter SYNC, default 0: 1 = two-flop synchronisers on in_req and out_ack; 0 = direct sampling.
REQ-004 Clk  input  1  single clock; all state updates on the rising edge.
REQ-005 extReset  input  1  asynchronous, active-low reset.
REQ-006 in_req  input  1  two-phase request from the sender; each toggle is one token.
REQ-007 in_data  input  WIDTH  bundled data, held stable from an in_req toggle until the matching in_ack toggle.
REQ-008 in_ack  output  1  two-phase acknowledge to the sender.
REQ-009 out_req  output  1  two-phase request to the receiver.
REQ-010 out_data  output  WIDTH  bundled data of the last stage.
REQ-011 out_ack  input  1  two-phase acknowledge from the receiver.
REQ-012 Count  output  clog2(DEPTH+1)  number of full stages.
REQ-013 Empty, Full  output  1 each  Count==0, Count==DEPTH.
REQ-014 Overrun  output  1  sticky sender protocol-violation flag.

Function
REQ-015 Each stage i (0..DEPTH-1) SHALL hold a phase bit p[i] and a data register d[i].
REQ-016 Define r = sampled in_req (after the synchronisers when SYNC=1) and a = sampled out_ack; p[-1]=r, d[-1]=in_data, p[DEPTH]=a.
REQ-017 Stage i SHALL be full when p[i]!=p[i+1] and empty when p[i]==p[i+1].
REQ-018 On each edge, stage i SHALL capture (p[i]<=p[i-1], d[i]<=d[i-1]) iff p[i-1]!=p[i] and stage i is empty; all stages evaluate pre-edge values simultaneously.
REQ-019 A stage not capturing SHALL hold p[i] and d[i].
REQ-020 in_ack SHALL equal p[0]; out_req SHALL equal p[DEPTH-1]; out_data SHALL equal d[DEPTH-1]; all are register outputs.
REQ-021 Forward latency SHALL be DEPTH cycles from r toggling to out_req toggling into an empty pipe, plus 2 cycles when SYNC=1.
REQ-022 Per-stage throughput SHALL be at most one token every 2 cycles, as in MouseTrap.
REQ-023 Tokens SHALL leave in arrival order, none lost or duplicated, while the sender obeys REQ-007.
REQ-024 Count SHALL be the combinational popcount of full stages over p[0..DEPTH].
REQ-025 Full pipeline with out_ack held: in_ack SHALL stop toggling, and no stage SHALL change.
REQ-026 Simultaneous out_ack toggle and new in_req token on one edge: the last stage empties and stage 0 captures on the same edge if stage 0 is empty.
REQ-027 Track last sampled value rl of r.
REQ-028 Overrun SHALL set when r!=rl while rl!=p[0] (a second toggle before acknowledge).
REQ-029 Overrun SHALL clear only on reset.
REQ-030 The token responsible for Overrun SHALL not be captured twice.
REQ-031 DEPTH=1 SHALL reduce to a single stage with p[-1]=r and p[1]=a.

Reset
REQ-032 extReset low SHALL immediately force all p[i]=0, d[i]=0, synchroniser flops=0, rl=0, Overrun=0.
REQ-033 During reset: in_ack=0, out_req=0, out_data=0, Count=0, Empty=1, Full=0.
REQ-034 Reset asserted mid-transfer SHALL discard all tokens in flight.
REQ-035 in_req high at reset release SHALL be treated as one pending token.

Verification (WIDTH=8, DEPTH=4, SYNC=0 unless stated)
REQ-036 Reset, then in_req 0->1 with in_data=0xA5 and out_ack=0 -> in_ack=1 after edge 1; out_req=1, out_data=0xA5 after edge 4; Count=1.
REQ-037 out_ack held 0, send 4 tokens 0x01..0x04 -> Full=1, Count=4; a 5th toggle is not acknowledged; toggling out_ack delivers 0x01..0x04 in order.
REQ-038 Continuous source and sink toggling every edge allowed -> one token per 2 cycles at the output; no loss.
REQ-039 in_req toggled twice with no in_ack toggle -> Overrun=1, stays 1 until extReset low.
REQ-040 SYNC=1, same stimulus as REQ-036 -> out_req toggles 6 cycles after the in_req edge.
REQ-041 Pipe holding 3 tokens, extReset pulsed low -> all outputs at reset values immediately; Count=0.
